// File: rtl/ddr_train_monitor.sv
// ddr_train_monitor
//   Watches DDR PHY calibration progress: timestamps each stage-done rising
//   edge with a free-running cycle count, enforces a global watchdog and
//   reports pass/fail with a cause code.
//
// Optional feature macro: DDR_TRAIN_MON_ORDER_CHK_EN
//   Defined   - a stage completing while an earlier stage is still outstanding
//               ends training with fail_code 2'b11.
//   Undefined - completion order is not checked.
//
// Ports
//   clk           monitor clock
//   rst_n         asynchronous active-low reset
//   start         one-cycle pulse, (re)starts a training run from any state
//   stage_done    level done flags, bit 0 = first stage
//   error_status  PHY error vector, nonzero = error
//   rd_idx        timestamp readout select
//   rd_ts         registered timestamp of stage rd_idx (0 when out of range)
//   state         00 IDLE, 01 RUN, 10 PASS, 11 FAIL
//   stage_seen    sticky per-stage completion bits
//   train_ok      high in PASS
//   train_fail    high in FAIL
//   fail_code     00 none, 01 timeout, 10 PHY error, 11 order violation
//   err_cap       error_status captured on entry to FAIL
//   total_cyc     cycle counter (frozen outside RUN)
//
// State | Meaning
// IDLE  | out of reset, waiting for start
// RUN   | counting cycles, capturing stage completions, checking exits
// PASS  | every stage completed before the watchdog; results held
// FAIL  | PHY error, order violation or watchdog; results held
module ddr_train_monitor #(
  parameter int          NUM_STAGES  = 5,
  parameter int          CNT_WIDTH   = 24,
  parameter int unsigned TIMEOUT_CYC = 24'hF0_0000,
  parameter int          ERR_WIDTH   = 8,
  localparam int         IDX_W       = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [NUM_STAGES-1:0] stage_done,
  input  logic [ERR_WIDTH-1:0]  error_status,
  input  logic [IDX_W-1:0]      rd_idx,
  output logic [CNT_WIDTH-1:0]  rd_ts,
  output logic [1:0]            state,
  output logic [NUM_STAGES-1:0] stage_seen,
  output logic                  train_ok,
  output logic                  train_fail,
  output logic [1:0]            fail_code,
  output logic [ERR_WIDTH-1:0]  err_cap,
  output logic [CNT_WIDTH-1:0]  total_cyc
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    PASS = 2'b10,
    FAIL = 2'b11
  } state_t;

  localparam logic [1:0] CODE_NONE    = 2'b00;
  localparam logic [1:0] CODE_TIMEOUT = 2'b01;
  localparam logic [1:0] CODE_PHY_ERR = 2'b10;
  localparam logic [1:0] CODE_ORDER   = 2'b11;

  state_t                  state_q, state_d;
  logic [CNT_WIDTH-1:0]    cnt_q;
  logic [NUM_STAGES-1:0]   seen_q, prev_q;
  logic [CNT_WIDTH-1:0]    ts_q [NUM_STAGES];
  logic [CNT_WIDTH-1:0]    ts_ext [2**IDX_W];
  logic [1:0]              fail_code_q, fail_code_d;
  logic [ERR_WIDTH-1:0]    err_cap_q;
  logic                    err_load;
  logic [CNT_WIDTH-1:0]    rd_ts_q;

  logic [NUM_STAGES-1:0]   capture;
  logic [NUM_STAGES-1:0]   seen_nxt;
  logic                    all_seen;
  logic                    timeout_hit;
  logic                    order_viol;
  logic [CNT_WIDTH-1:0]    cnt_inc;

  // A capture needs a fresh rising edge and a stage not yet recorded, so a
  // flag that drops and rises again never overwrites its first timestamp.
  assign capture     = stage_done & ~prev_q & ~seen_q;
  assign seen_nxt    = seen_q | capture;
  assign all_seen    = &seen_nxt;
  assign timeout_hit = (cnt_q == CNT_WIDTH'(TIMEOUT_CYC)) && !all_seen;
  assign cnt_inc     = (&cnt_q) ? cnt_q : cnt_q + CNT_WIDTH'(1);

`ifdef DDR_TRAIN_MON_ORDER_CHK_EN
  // Stages captured together count as in order; only a stage left behind
  // (neither seen before nor captured now) flags a violation.
  always_comb begin
    logic all_below;
    order_viol = 1'b0;
    all_below  = seen_nxt[0];
    for (int k = 1; k < NUM_STAGES; k++) begin
      if (capture[k] && !all_below) order_viol = 1'b1;
      all_below = all_below & seen_nxt[k];
    end
  end
`else
  assign order_viol = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    fail_code_d = fail_code_q;
    err_load    = 1'b0;
    if (start) begin
      state_d     = RUN;
      fail_code_d = CODE_NONE;
    end else if (state_q == RUN) begin
      if (|error_status) begin
        state_d     = FAIL;
        fail_code_d = CODE_PHY_ERR;
        err_load    = 1'b1;
      end else if (order_viol) begin
        state_d     = FAIL;
        fail_code_d = CODE_ORDER;
      end else if (timeout_hit) begin
        state_d     = FAIL;
        fail_code_d = CODE_TIMEOUT;
      end else if (all_seen) begin
        state_d     = PASS;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      fail_code_q <= CODE_NONE;
    end else begin
      state_q     <= state_d;
      fail_code_q <= fail_code_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      seen_q    <= '0;
      prev_q    <= '0;
      err_cap_q <= '0;
      for (int i = 0; i < NUM_STAGES; i++) ts_q[i] <= '0;
    end else if (start) begin
      cnt_q     <= '0;
      seen_q    <= '0;
      prev_q    <= '0;
      err_cap_q <= '0;
      for (int i = 0; i < NUM_STAGES; i++) ts_q[i] <= '0;
    end else if (state_q == RUN) begin
      // The counter also advances on the exit cycle, so total_cyc reads one
      // past the counter value at which the exit was detected.
      cnt_q  <= cnt_inc;
      seen_q <= seen_nxt;
      prev_q <= stage_done;
      for (int i = 0; i < NUM_STAGES; i++) begin
        if (capture[i]) ts_q[i] <= cnt_q;
      end
      if (err_load) err_cap_q <= error_status;
    end
  end

  // Pad the timestamp array to the full rd_idx range so out-of-range
  // selects read back zero without a separate bounds compare.
  for (genvar g = 0; g < 2**IDX_W; g++) begin : g_ts_ext
    if (g < NUM_STAGES) begin : g_real
      assign ts_ext[g] = ts_q[g];
    end else begin : g_pad
      assign ts_ext[g] = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_ts_q <= '0;
    else        rd_ts_q <= ts_ext[rd_idx];
  end

  assign rd_ts      = rd_ts_q;
  assign state      = state_q;
  assign stage_seen = seen_q;
  assign train_ok   = (state_q == PASS);
  assign train_fail = (state_q == FAIL);
  assign fail_code  = fail_code_q;
  assign err_cap    = err_cap_q;
  assign total_cyc  = cnt_q;

endmodule

// File: doc/ddr_train_monitor.md
# ddr_train_monitor

Synthesizable, parametrised monitor for DDR PHY calibration progress. It watches the per-stage done flags and the error vector of the PHY main controller, for example init, write-levelling, read/gate calibration, write calibration and eye calibration. It timestamps each stage completion with a free-running cycle count and enforces a global watchdog, then reports pass/fail with a cause code. It sits beside the DDR IP top level and feeds the UART/LED status path, replacing simulation-only `$display` milestone tracking with on-chip observability.

## Interface
Parameters:
- NUM_STAGES, 5, number of calibration stage done flags monitored (1..16)
- CNT_WIDTH, 24, width of cycle counter and timestamps
- TIMEOUT_CYC, 24'hF0_0000, watchdog limit in cycles; must be < 2^CNT_WIDTH
- ERR_WIDTH, 8, width of PHY error_status vector

Ports:
- clk  in  1  monitor clock; all inputs synchronous to it
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  single-cycle pulse: PHY reset released, training begins
- stage_done  in  NUM_STAGES  level done flags, bit 0 = first stage
- error_status  in  ERR_WIDTH  PHY error vector; nonzero = error
- rd_idx  in  clog2(NUM_STAGES) (min 1)  timestamp readout select
- rd_ts  out  CNT_WIDTH  registered timestamp of stage rd_idx
- state  out  2  00 IDLE, 01 RUN, 10 PASS, 11 FAIL
- stage_seen  out  NUM_STAGES  sticky per-stage completion bits
- train_ok  out  1  high in PASS
- train_fail  out  1  high in FAIL
- fail_code  out  2  00 none, 01 timeout, 10 PHY error, 11 order violation
- err_cap  out  ERR_WIDTH  error_status captured on entry to FAIL
- total_cyc  out  CNT_WIDTH  cycle counter value

## Operation
- Reset: state=IDLE; all outputs, timestamps, stage_seen, counter and prev-flag registers are 0.
- IDLE: wait for start. On start, clear the timestamps, stage_seen, fail_code, err_cap, counter and prev-flag register, then go to RUN.
- RUN: the counter increments each cycle and saturates at all-ones. For each stage i: if stage_done[i]=1, prev[i]=0 and stage_seen[i]=0, set stage_seen[i] and ts[i]=current counter. A flag already high on the first RUN cycle therefore gets timestamp 0.
  - Several stages rising in one cycle all receive the same timestamp.
  - A stage_done that later falls is ignored; stage_seen stays set.
- Exit checks, evaluated each RUN cycle in priority order:
  1. error_status≠0 → FAIL, code 10, err_cap=error_status.
  2. Order violation → FAIL, code 11 (see Configuration).
  3. counter==TIMEOUT_CYC with stage_seen (including this cycle's captures) not all-ones → FAIL, code 01.
  4. All stages seen (including this cycle's captures) → PASS.
  - When an order violation and completion occur in the same cycle, FAIL wins.
- PASS/FAIL: the counter freezes; outputs hold until the next start or reset. start in any state, including RUN, restarts as in IDLE.
- Readout: rd_ts <= ts[rd_idx] every cycle, in any state. rd_idx ≥ NUM_STAGES returns 0.

## Timing
- start sampled at edge N → state=RUN after N; the first RUN cycle has counter 0.
- stage_done[i] high in RUN cycle with counter=k → ts[i]=k, and stage_seen[i] is visible after the next edge.
- Exit condition detected in cycle with counter=k → state/train_ok/train_fail/fail_code are valid after that edge; total_cyc holds k+1.
- rd_ts latency: 1 cycle from rd_idx.
- rst_n assertion mid-RUN clears everything immediately, with no completion report.

## Configuration
- DDR_TRAIN_MON_ORDER_CHK_EN defined: in RUN, a new capture of stage k while any stage j<k is neither already seen nor captured in the same cycle → FAIL code 11.
- Not defined: completion order is unchecked and code 11 is never produced. Capture and timestamp behaviour is otherwise identical.

## Test plan
- Defaults: start, then raise stage_done bits 0..4 cumulatively at counter 100, 200, 300, 400, 500 → PASS, train_ok=1, rd_ts for idx 0..4 = 100..500, total_cyc=501.
- error_status=8'h04 at counter 50 with stage 0 already seen → FAIL, fail_code=10, err_cap=8'h04, stage_seen=5'b00001.
- Set TIMEOUT_CYC=1000 and complete only stages 0–2 → FAIL, code 01 after counter 1000; total_cyc=1001.
- With the macro defined, raise stage 2 before stage 1 → FAIL, code 11. Same stimulus without the macro, then the remaining stages → PASS.
- All five flags high at start → PASS after the first RUN cycle, all timestamps 0. Toggle rst_n low mid-RUN → all outputs 0 at once. A second start after PASS re-clears everything and reruns.
- Sweep rd_idx 0..7 in PASS → rd_ts follows with 1-cycle lag; indices 5..7 return 0.
